// File: rtl/fphub_pkg.sv
// Shared types and helpers for the FPHUB adder arbitration slice.
package fphub_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_BUSY,
    ARB_RESP
  } arb_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fphub_rr_arbiter.sv
// Round-robin grant selection: first asserted request at or after the pointer, wrapping.
module fphub_rr_arbiter
  import fphub_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int IdW    = clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    ptr,
  output logic [NumReq-1:0] grant,
  output logic [IdW-1:0]    grant_idx,
  output logic              grant_valid
);

  always_comb begin
    int cand;
    cand        = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < NumReq; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!grant_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IdW'(cand);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fphub_adder_arbiter.sv
// Shares one FPHUB adder among several requesters with round-robin grants,
// a single-op sequencer around the adder start/finish protocol, and a finish watchdog.
module fphub_adder_arbiter
  import fphub_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int M             = 23,
  parameter int E             = 8,
  parameter int TimeoutCycles = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*(E+M+1)-1:0]     req_x_i,
  input  logic [NumReq*(E+M+1)-1:0]     req_y_i,
  input  logic [NumReq-1:0]             req_sub_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [clog2(NumReq)-1:0]      resp_id_o,
  output logic [E+M:0]                  resp_z_o,
  output logic                          resp_timeout_o,
  output logic                          adu_start_o,
  output logic [E+M:0]                  adu_x_o,
  output logic [E+M:0]                  adu_y_o,
  input  logic [E+M:0]                  adu_z_i,
  input  logic                          adu_finish_i,
  output logic                          busy_o
);

  localparam int W   = E + M + 1;
  localparam int IdW = clog2(NumReq);
  localparam int TW  = clog2(TimeoutCycles) + 1;

  arb_state_e state_q, state_d;

  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]     timer_q, timer_next;
  logic              timer_expire;
  logic [W-1:0]      x_q, y_q, z_q;
  logic [IdW-1:0]    id_q;
  logic              timeout_q;

  logic [NumReq-1:0] grant;
  logic [IdW-1:0]    grant_idx;
  logic              grant_valid;
  logic [W-1:0]      sel_x, sel_y;
  logic              sel_sub;

  logic load_op, cap_finish, cap_timeout, timer_clr;

  fphub_rr_arbiter #(
    .NumReq (NumReq),
    .IdW    (IdW)
  ) u_rr (
    .req         (req_valid_i),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel_x   = req_x_i[int'(grant_idx)*W +: W];
  assign sel_y   = req_y_i[int'(grant_idx)*W +: W];
  assign sel_sub = req_sub_i[grant_idx];

  // The watchdog fires when the incremented count would reach TimeoutCycles-1,
  // so an op that never finishes leaves BUSY TimeoutCycles cycles after START.
  assign timer_next   = timer_q + TW'(1);
  assign timer_expire = (timer_next == TW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    req_ready_o = '0;
    load_op     = 1'b0;
    cap_finish  = 1'b0;
    cap_timeout = 1'b0;
    timer_clr   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid && !flush_i) begin
          req_ready_o = grant;
          load_op     = 1'b1;
          ptr_d       = (grant_idx == IdW'(NumReq - 1)) ? '0 : grant_idx + IdW'(1);
          state_d     = ARB_START;
        end
      end
      ARB_START: begin
        timer_clr = 1'b1;
        state_d   = ARB_BUSY;
      end
      ARB_BUSY: begin
        if (adu_finish_i) begin
          cap_finish = 1'b1;
          state_d    = ARB_RESP;
        end else if (timer_expire) begin
          cap_timeout = 1'b1;
          state_d     = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (resp_ready_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    // Flush drops whatever is in flight but keeps the fairness pointer.
    if (flush_i) begin
      state_d     = ARB_IDLE;
      ptr_d       = ptr_q;
      load_op     = 1'b0;
      cap_finish  = 1'b0;
      cap_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      timer_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      id_q      <= '0;
      z_q       <= '0;
      timeout_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (load_op) begin
        x_q  <= sel_x;
        y_q  <= sel_y ^ {sel_sub, {(W-1){1'b0}}};
        id_q <= grant_idx;
      end
      if (timer_clr)                 timer_q <= '0;
      else if (state_q == ARB_BUSY)  timer_q <= timer_next;
      if (cap_finish) begin
        z_q       <= adu_z_i;
        timeout_q <= 1'b0;
      end else if (cap_timeout) begin
        z_q       <= '0;
        timeout_q <= 1'b1;
      end
    end
  end

  assign adu_start_o    = (state_q == ARB_START);
  assign adu_x_o        = x_q;
  assign adu_y_o        = y_q;
  assign resp_valid_o   = (state_q == ARB_RESP);
  assign resp_id_o      = id_q;
  assign resp_z_o       = z_q;
  assign resp_timeout_o = timeout_q;
  assign busy_o         = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_fphub_adder_arbiter.sv
// Directed bench for fphub_adder_arbiter with a k-cycle adder model (Z = X+Y as raw bits).
module tb_fphub_adder_arbiter;

  localparam int NumReq        = 2;
  localparam int M             = 23;
  localparam int E             = 8;
  localparam int TimeoutCycles = 8;

  logic        clk_i        = 1'b0;
  logic        rst_ni       = 1'b0;
  logic        flush_i      = 1'b0;
  logic [1:0]  req_valid_i  = '0;
  logic [1:0]  req_ready_o;
  logic [63:0] req_x_i      = '0;
  logic [63:0] req_y_i      = '0;
  logic [1:0]  req_sub_i    = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [0:0]  resp_id_o;
  logic [31:0] resp_z_o;
  logic        resp_timeout_o;
  logic        adu_start_o;
  logic [31:0] adu_x_o;
  logic [31:0] adu_y_o;
  logic [31:0] adu_z_i      = '0;
  logic        adu_finish_i = 1'b0;
  logic        busy_o;

  int compared   = 0;
  int mismatched = 0;

  fphub_adder_arbiter #(
    .NumReq        (NumReq),
    .M             (M),
    .E             (E),
    .TimeoutCycles (TimeoutCycles)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_x_i        (req_x_i),
    .req_y_i        (req_y_i),
    .req_sub_i      (req_sub_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_id_o      (resp_id_o),
    .resp_z_o       (resp_z_o),
    .resp_timeout_o (resp_timeout_o),
    .adu_start_o    (adu_start_o),
    .adu_x_o        (adu_x_o),
    .adu_y_o        (adu_y_o),
    .adu_z_i        (adu_z_i),
    .adu_finish_i   (adu_finish_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Adder model: finish is high during the k-th cycle after the start cycle.
  int          adderK     = 3;
  bit          adderNever = 1'b0;
  int          adderCnt   = 0;
  logic [31:0] adderZ     = '0;

  always @(negedge clk_i) begin
    adu_finish_i = 1'b0;
    if (adu_start_o) begin
      adderCnt = adderNever ? 0 : adderK;
      adderZ   = adu_x_o + adu_y_o;
    end else if (adderCnt > 0) begin
      adderCnt = adderCnt - 1;
      if (adderCnt == 0) begin
        adu_finish_i = 1'b1;
        adu_z_i      = adderZ;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] x, input logic [31:0] y,
                               input logic sub);
    req_x_i[idx*32 +: 32] = x;
    req_y_i[idx*32 +: 32] = y;
    req_sub_i[idx]        = sub;
    req_valid_i[idx]      = 1'b1;
  endtask

  // Entered at a falling edge; returns 1 time unit after the edge where ready is seen.
  task automatic waitReady(input string tag, input logic [1:0] expGrant);
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req_ready_o != 2'b00) break;
      @(negedge clk_i);
    end
    checkOutput({tag, "_ready"}, 32'(req_ready_o), 32'(expGrant));
  endtask

  // Entered at a falling edge; waits for the response, checks it, then consumes it.
  task automatic waitResp(input string tag, input logic expId, input logic [31:0] expZ,
                          input logic expTo);
    for (int i = 0; i < 40; i++) begin
      if (resp_valid_o) break;
      @(negedge clk_i);
    end
    checkOutput({tag, "_valid"},   32'(resp_valid_o),   32'd1);
    checkOutput({tag, "_id"},      32'(resp_id_o),      32'(expId));
    checkOutput({tag, "_z"},       resp_z_o,            expZ);
    checkOutput({tag, "_timeout"}, 32'(resp_timeout_o), 32'(expTo));
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
  endtask

  localparam logic [31:0] X0 = 32'h3F80_0000;
  localparam logic [31:0] Y0 = 32'h4000_0000;
  localparam logic [31:0] X1 = 32'h4040_0000;
  localparam logic [31:0] Y1 = 32'h3F80_0000;
  localparam logic [31:0] Z0 = 32'h7F80_0000;
  localparam logic [31:0] Z1 = 32'h7FC0_0000;

  initial begin
    $display("[TB] start");
    #1;
    checkOutput("rst_busy",    32'(busy_o),         32'd0);
    checkOutput("rst_valid",   32'(resp_valid_o),   32'd0);
    checkOutput("rst_start",   32'(adu_start_o),    32'd0);
    checkOutput("rst_ready",   32'(req_ready_o),    32'd0);
    checkOutput("rst_x",       adu_x_o,             32'd0);
    checkOutput("rst_y",       adu_y_o,             32'd0);
    checkOutput("rst_z",       resp_z_o,            32'd0);
    checkOutput("rst_id",      32'(resp_id_o),      32'd0);
    checkOutput("rst_timeout", 32'(resp_timeout_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single op from requester 0 with exact cycle timing, k=3.
    adderK = 3;
    applyStimulus(0, X0, Y0, 1'b0);
    #1;
    checkOutput("t1_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    req_valid_i = '0;
    checkOutput("t1_start", 32'(adu_start_o), 32'd1);
    checkOutput("t1_x",     adu_x_o,          X0);
    checkOutput("t1_y",     adu_y_o,          Y0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk_i);
      checkOutput("t1_early", 32'(resp_valid_o), 32'd0);
    end
    @(negedge clk_i);
    waitResp("t1", 1'b0, Z0, 1'b0);
    checkOutput("t1_idle", 32'(busy_o), 32'd0);

    // Reset in the middle of an op; pointer now favours requester 1.
    applyStimulus(1, X1, Y1, 1'b0);
    waitReady("rstmid", 2'b10);
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checkOutput("rstmid_busy",  32'(busy_o),       32'd0);
    checkOutput("rstmid_x",     adu_x_o,           32'd0);
    checkOutput("rstmid_y",     adu_y_o,           32'd0);
    checkOutput("rstmid_valid", 32'(resp_valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    checkOutput("rstmid_stray", 32'(resp_valid_o), 32'd0);

    // Both requesters always valid: grants alternate starting at 0.
    adderK = 2;
    applyStimulus(0, X0, Y0, 1'b0);
    applyStimulus(1, X1, Y1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      waitReady("rr", (n % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk_i);
      waitResp("rr", (n % 2 == 0) ? 1'b0 : 1'b1, (n % 2 == 0) ? Z0 : Z1, 1'b0);
    end
    req_valid_i = '0;

    // Subtract on requester 1 flips the sign of Y.
    applyStimulus(1, X0, Y0, 1'b1);
    waitReady("sub", 2'b10);
    @(negedge clk_i);
    req_valid_i = '0;
    req_sub_i   = '0;
    checkOutput("sub_start", 32'(adu_start_o), 32'd1);
    checkOutput("sub_x",     adu_x_o,          X0);
    checkOutput("sub_y",     adu_y_o,          32'hC000_0000);
    waitResp("sub", 1'b1, 32'hFF80_0000, 1'b0);

    // Response back-pressure with another requester waiting.
    adderK = 1;
    applyStimulus(0, X0, Y0, 1'b0);
    waitReady("bp", 2'b01);
    @(negedge clk_i);
    req_valid_i = '0;
    applyStimulus(1, X1, Y1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (resp_valid_o) break;
      @(negedge clk_i);
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("bp_valid", 32'(resp_valid_o), 32'd1);
      checkOutput("bp_z",     resp_z_o,          Z0);
      checkOutput("bp_id",    32'(resp_id_o),    32'd0);
      checkOutput("bp_ready", 32'(req_ready_o),  32'd0);
      @(negedge clk_i);
    end
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    waitReady("bp_next", 2'b10);
    @(negedge clk_i);
    req_valid_i = '0;
    waitResp("bp_next", 1'b1, Z1, 1'b0);

    // Adder never finishes: watchdog responds 8 cycles after START.
    adderNever = 1'b1;
    applyStimulus(0, X0, Y0, 1'b0);
    waitReady("to", 2'b01);
    @(negedge clk_i);
    req_valid_i = '0;
    checkOutput("to_start", 32'(adu_start_o), 32'd1);
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk_i);
      checkOutput("to_early", 32'(resp_valid_o), 32'd0);
    end
    @(negedge clk_i);
    checkOutput("to_valid",   32'(resp_valid_o),   32'd1);
    checkOutput("to_timeout", 32'(resp_timeout_o), 32'd1);
    checkOutput("to_z",       resp_z_o,            32'd0);
    checkOutput("to_id",      32'(resp_id_o),      32'd0);
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    adderNever = 1'b0;
    adderK     = 2;
    applyStimulus(1, X1, Y1, 1'b0);
    waitReady("to_next", 2'b10);
    @(negedge clk_i);
    req_valid_i = '0;
    waitResp("to_next", 1'b1, Z1, 1'b0);

    // Flush in BUSY, then a late finish that must be ignored.
    adderK = 5;
    applyStimulus(0, X0, Y0, 1'b0);
    waitReady("fl", 2'b01);
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    applyStimulus(1, X1, Y1, 1'b0);
    #1;
    checkOutput("fl_ready", 32'(req_ready_o), 32'd0);
    checkOutput("fl_busy",  32'(busy_o),      32'd1);
    @(negedge clk_i);
    flush_i     = 1'b0;
    req_valid_i = '0;
    checkOutput("fl_idle", 32'(busy_o), 32'd0);
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk_i);
      checkOutput("fl_noresp", 32'(resp_valid_o), 32'd0);
      checkOutput("fl_nobusy", 32'(busy_o),       32'd0);
    end
    adderK = 2;
    applyStimulus(0, X0, Y0, 1'b0);
    applyStimulus(1, X1, Y1, 1'b0);
    waitReady("fl_next", 2'b10);
    @(negedge clk_i);
    req_valid_i = '0;
    waitResp("fl_next", 1'b1, Z1, 1'b0);

    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
